// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipelined MIPS control unit: opcodes, ALUOp
// classes, control-word layout and the per-stage register slices.
`timescale 1ns/1ps
package pipe_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b11;

  localparam int CW_ALUSRC   = 0;
  localparam int CW_ALUOP_LO = 1;
  localparam int CW_ALUOP_HI = 2;
  localparam int CW_REGDST   = 3;
  localparam int CW_MEMREAD  = 4;
  localparam int CW_MEMWRITE = 5;
  localparam int CW_REGWRITE = 6;
  localparam int CW_MEMTOREG = 7;
  localparam int CW_W        = 8;

  // Field order mirrors the bit indices above (MSB = MemtoReg).
  typedef struct packed {
    logic       memtoreg;
    logic       regwrite;
    logic       memwrite;
    logic       memread;
    logic       regdst;
    logic [1:0] aluop;
    logic       alusrc;
  } ctrl_word_t;

  typedef struct packed {
    logic memtoreg;
    logic regwrite;
    logic memwrite;
    logic memread;
  } ex_mem_t;

  typedef struct packed {
    logic memtoreg;
    logic regwrite;
  } mem_wb_t;

  localparam ctrl_word_t CTRL_NOP = '0;

endpackage

// File: rtl/pipe_ctrl_unit_decode.sv
// Pure combinational opcode decoder: control word, branch/jump selects and
// the illegal-opcode flag for the instruction sitting in ID.
`timescale 1ns/1ps
module ctrl_decode
  import pipe_ctrl_pkg::*;
#(
  parameter int OP_W = 6
) (
  input  logic [OP_W-1:0] op_i,
  input  logic            valid_i,
  output ctrl_word_t      word_o,
  output logic            branch_o,
  output logic            jump_o,
  output logic            illegal_o
);

  logic [CW_W-1:0] word_bits;
  logic            known;

  always_comb begin
    word_bits = '0;
    known     = 1'b1;
    branch_o  = 1'b0;
    jump_o    = 1'b0;
    case (op_i)
      OP_W'(OP_RTYPE): begin
        word_bits[CW_ALUOP_HI:CW_ALUOP_LO] = ALUOP_FUNCT;
        word_bits[CW_REGDST]               = 1'b1;
        word_bits[CW_REGWRITE]             = 1'b1;
      end
      OP_W'(OP_ADDI): begin
        word_bits[CW_ALUSRC]               = 1'b1;
        word_bits[CW_ALUOP_HI:CW_ALUOP_LO] = ALUOP_ADD;
        word_bits[CW_REGWRITE]             = 1'b1;
      end
      OP_W'(OP_LW): begin
        word_bits[CW_ALUSRC]               = 1'b1;
        word_bits[CW_ALUOP_HI:CW_ALUOP_LO] = ALUOP_ADD;
        word_bits[CW_MEMREAD]              = 1'b1;
        word_bits[CW_REGWRITE]             = 1'b1;
        word_bits[CW_MEMTOREG]             = 1'b1;
      end
      OP_W'(OP_SW): begin
        word_bits[CW_ALUSRC]               = 1'b1;
        word_bits[CW_ALUOP_HI:CW_ALUOP_LO] = ALUOP_ADD;
        word_bits[CW_MEMWRITE]             = 1'b1;
      end
      OP_W'(OP_BEQ): begin
        word_bits[CW_ALUOP_HI:CW_ALUOP_LO] = ALUOP_SUB;
        branch_o                           = 1'b1;
      end
      OP_W'(OP_J): begin
        jump_o = 1'b1;
      end
      default: begin
        known = 1'b0;
      end
    endcase
    // An invalid slot is never illegal; it simply becomes a bubble upstream.
    illegal_o = valid_i & ~known;
    word_o    = ctrl_word_t'(word_bits);
  end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipelined control unit: ID decode, load-use hazard stall, branch/jump
// flush, ID/EX -> EX/MEM -> MEM/WB control registers and illegal-op counter.
`timescale 1ns/1ps
module pipe_ctrl_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int OP_W      = 6,
  parameter int REG_W     = 5,
  parameter int ALUOP_W   = 2,
  parameter int EN_HAZARD = 1,
  parameter int CNT_W     = 8
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               valid_i,
  input  logic [OP_W-1:0]    op_i,
  input  logic [REG_W-1:0]   id_rs_i,
  input  logic [REG_W-1:0]   id_rt_i,
  input  logic [REG_W-1:0]   ex_rt_i,
  input  logic               flush_i,
  output logic               branch_o,
  output logic               jump_o,
  output logic               stall_o,
  output logic               ex_alusrc_o,
  output logic [ALUOP_W-1:0] ex_aluop_o,
  output logic               ex_regdst_o,
  output logic               ex_memread_o,
  output logic               mem_read_o,
  output logic               mem_write_o,
  output logic               wb_regwrite_o,
  output logic               wb_memtoreg_o,
  output logic               illegal_o,
  output logic [CNT_W-1:0]   illegal_cnt_o
);

  ctrl_word_t dec_word;
  logic       dec_branch;
  logic       dec_jump;
  logic       dec_illegal;

  ctrl_word_t id_ex_q, id_ex_d;
  ex_mem_t    ex_mem_q, ex_mem_d;
  mem_wb_t    mem_wb_q, mem_wb_d;
  logic [CNT_W-1:0] illegal_cnt_q, illegal_cnt_d;
  logic             illegal_q, illegal_d;

  logic hazard;
  logic bubble;
  logic count_en;

  ctrl_decode #(
    .OP_W (OP_W)
  ) u_decode (
    .op_i      (op_i),
    .valid_i   (valid_i),
    .word_o    (dec_word),
    .branch_o  (dec_branch),
    .jump_o    (dec_jump),
    .illegal_o (dec_illegal)
  );

  // Register 0 is hard-wired zero, so a load targeting it never creates a hazard.
  assign hazard = (EN_HAZARD != 0) && id_ex_q.memread && (ex_rt_i != '0) &&
                  ((ex_rt_i == id_rs_i) || (ex_rt_i == id_rt_i));

  assign stall_o  = hazard;
  assign bubble   = ~valid_i | dec_illegal | hazard | flush_i;
  assign count_en = dec_illegal & ~hazard & ~flush_i;

  assign branch_o = rst_n_i & dec_branch & valid_i & ~hazard & ~flush_i;
  assign jump_o   = rst_n_i & dec_jump & valid_i & ~hazard & ~flush_i;

  always_comb begin
    id_ex_d  = bubble ? CTRL_NOP : dec_word;

    ex_mem_d          = '0;
    ex_mem_d.memread  = id_ex_q.memread;
    ex_mem_d.memwrite = id_ex_q.memwrite;
    ex_mem_d.regwrite = id_ex_q.regwrite;
    ex_mem_d.memtoreg = id_ex_q.memtoreg;

    mem_wb_d          = '0;
    mem_wb_d.regwrite = ex_mem_q.regwrite;
    mem_wb_d.memtoreg = ex_mem_q.memtoreg;

    illegal_cnt_d = illegal_cnt_q;
    if (count_en && (illegal_cnt_q != {CNT_W{1'b1}})) begin
      illegal_cnt_d = illegal_cnt_q + CNT_W'(1);
    end
    illegal_d = illegal_q | count_en;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      id_ex_q       <= CTRL_NOP;
      ex_mem_q      <= '0;
      mem_wb_q      <= '0;
      illegal_cnt_q <= '0;
      illegal_q     <= 1'b0;
    end else begin
      id_ex_q       <= id_ex_d;
      ex_mem_q      <= ex_mem_d;
      mem_wb_q      <= mem_wb_d;
      illegal_cnt_q <= illegal_cnt_d;
      illegal_q     <= illegal_d;
    end
  end

  assign ex_alusrc_o  = id_ex_q.alusrc;
  assign ex_regdst_o  = id_ex_q.regdst;
  assign ex_memread_o = id_ex_q.memread;

  // ALUOp is zero-extended when the datapath uses a wider field.
  for (genvar gi = 0; gi < ALUOP_W; gi++) begin : g_aluop
    if (gi < 2) begin : g_bit
      assign ex_aluop_o[gi] = id_ex_q.aluop[gi];
    end else begin : g_zero
      assign ex_aluop_o[gi] = 1'b0;
    end
  end

  assign mem_read_o    = ex_mem_q.memread;
  assign mem_write_o   = ex_mem_q.memwrite;
  assign wb_regwrite_o = mem_wb_q.regwrite;
  assign wb_memtoreg_o = mem_wb_q.memtoreg;
  assign illegal_o     = illegal_q;
  assign illegal_cnt_o = illegal_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Self-checking bench: two control units (hazard on / 2-bit counter, and
// hazard off / 3-bit ALUOp) share stimulus and are checked against a model.
`timescale 1ns/1ps
module tb_pipe_ctrl_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       valid;
  logic [5:0] op;
  logic [4:0] rs, rt, exrt;
  logic       flush;

  logic       u0_branch, u0_jump, u0_stall, u0_alusrc, u0_regdst, u0_memread;
  logic [1:0] u0_aluop;
  logic       u0_mrd, u0_mwr, u0_wbrw, u0_wbm2r, u0_ill;
  logic [1:0] u0_cnt;

  logic       u1_branch, u1_jump, u1_stall, u1_alusrc, u1_regdst, u1_memread;
  logic [2:0] u1_aluop;
  logic       u1_mrd, u1_mwr, u1_wbrw, u1_wbm2r, u1_ill;
  logic [7:0] u1_cnt;

  int n_vec  = 0;
  int n_miss = 0;

  // Model state: last three accepted ID words (index 0 = now in EX).
  logic [7:0] hist [2][3];
  int         cnt_m [2];
  logic       ill_m [2];
  int         cnt_max [2] = '{3, 255};
  int         hz [2] = '{1, 0};

  always #5 clk = ~clk;

  pipe_ctrl_unit #(.OP_W(6), .REG_W(5), .ALUOP_W(2), .EN_HAZARD(1), .CNT_W(2)) u0 (
    .clk_i(clk), .rst_n_i(rst_n), .valid_i(valid), .op_i(op),
    .id_rs_i(rs), .id_rt_i(rt), .ex_rt_i(exrt), .flush_i(flush),
    .branch_o(u0_branch), .jump_o(u0_jump), .stall_o(u0_stall),
    .ex_alusrc_o(u0_alusrc), .ex_aluop_o(u0_aluop), .ex_regdst_o(u0_regdst),
    .ex_memread_o(u0_memread), .mem_read_o(u0_mrd), .mem_write_o(u0_mwr),
    .wb_regwrite_o(u0_wbrw), .wb_memtoreg_o(u0_wbm2r),
    .illegal_o(u0_ill), .illegal_cnt_o(u0_cnt)
  );

  pipe_ctrl_unit #(.OP_W(6), .REG_W(5), .ALUOP_W(3), .EN_HAZARD(0), .CNT_W(8)) u1 (
    .clk_i(clk), .rst_n_i(rst_n), .valid_i(valid), .op_i(op),
    .id_rs_i(rs), .id_rt_i(rt), .ex_rt_i(exrt), .flush_i(flush),
    .branch_o(u1_branch), .jump_o(u1_jump), .stall_o(u1_stall),
    .ex_alusrc_o(u1_alusrc), .ex_aluop_o(u1_aluop), .ex_regdst_o(u1_regdst),
    .ex_memread_o(u1_memread), .mem_read_o(u1_mrd), .mem_write_o(u1_mwr),
    .wb_regwrite_o(u1_wbrw), .wb_memtoreg_o(u1_wbm2r),
    .illegal_o(u1_ill), .illegal_cnt_o(u1_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns {known, branch, jump, word[7:0]} straight from the opcode table.
  function automatic logic [10:0] ref_decode(input logic [5:0] o);
    case (o)
      6'b000000: return {3'b100, 8'h4E};
      6'b001000: return {3'b100, 8'h41};
      6'b100011: return {3'b100, 8'hD1};
      6'b101011: return {3'b100, 8'h21};
      6'b000100: return {3'b110, 8'h02};
      6'b000010: return {3'b101, 8'h00};
      default:   return {3'b000, 8'h00};
    endcase
  endfunction

  task automatic clear_model();
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 3; j++) hist[k][j] = 8'h00;
      cnt_m[k] = 0;
      ill_m[k] = 1'b0;
    end
  endtask

  task automatic check_regs(input int k);
    logic [7:0] w0, w1, w2;
    logic [5:0] obs_ex, exp_ex;
    w0 = hist[k][0];
    w1 = hist[k][1];
    w2 = hist[k][2];
    exp_ex = {w0[0], 1'b0, w0[2:1], w0[3], w0[4]};
    if (k == 0) begin
      obs_ex = {u0_alusrc, 1'b0, u0_aluop, u0_regdst, u0_memread};
      chk("u0 ex", 32'(obs_ex), 32'(exp_ex));
      chk("u0 mem", 32'({u0_mrd, u0_mwr}), 32'({w1[4], w1[5]}));
      chk("u0 wb", 32'({u0_wbrw, u0_wbm2r}), 32'({w2[6], w2[7]}));
      chk("u0 illegal", 32'(u0_ill), 32'(ill_m[0]));
      chk("u0 cnt", 32'(u0_cnt), 32'(cnt_m[0]));
    end else begin
      obs_ex = {u1_alusrc, u1_aluop, u1_regdst, u1_memread};
      chk("u1 ex", 32'(obs_ex), 32'(exp_ex));
      chk("u1 mem", 32'({u1_mrd, u1_mwr}), 32'({w1[4], w1[5]}));
      chk("u1 wb", 32'({u1_wbrw, u1_wbm2r}), 32'({w2[6], w2[7]}));
      chk("u1 illegal", 32'(u1_ill), 32'(ill_m[1]));
      chk("u1 cnt", 32'(u1_cnt), 32'(cnt_m[1]));
    end
  endtask

  // One ID-stage cycle: drive, check comb outputs, clock, check registers.
  task automatic step(input logic v, input logic [5:0] o, input logic [4:0] s,
                      input logic [4:0] t, input logic [4:0] e, input logic f);
    logic [10:0] d;
    logic        st;
    logic [7:0]  new_w [2];
    logic        inc [2];
    logic [2:0]  obs_c;
    valid = v; op = o; rs = s; rt = t; exrt = e; flush = f;
    #1;
    d = ref_decode(o);
    for (int k = 0; k < 2; k++) begin
      st = (hz[k] != 0) && hist[k][0][4] && (e != 5'd0) && ((e == s) || (e == t));
      obs_c = (k == 0) ? {u0_stall, u0_branch, u0_jump} : {u1_stall, u1_branch, u1_jump};
      chk((k == 0) ? "u0 stall" : "u1 stall", 32'(obs_c[2]), 32'(st));
      chk((k == 0) ? "u0 branch" : "u1 branch", 32'(obs_c[1]), 32'(d[9] && v && !st && !f));
      chk((k == 0) ? "u0 jump" : "u1 jump", 32'(obs_c[0]), 32'(d[8] && v && !st && !f));
      new_w[k] = (!v || !d[10] || st || f) ? 8'h00 : d[7:0];
      inc[k]   = v && !d[10] && !st && !f;
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      hist[k][2] = hist[k][1];
      hist[k][1] = hist[k][0];
      hist[k][0] = new_w[k];
      if (inc[k]) begin
        ill_m[k] = 1'b1;
        if (cnt_m[k] < cnt_max[k]) cnt_m[k]++;
      end
    end
    #1;
    check_regs(0);
    check_regs(1);
  endtask

  task automatic check_all_zero();
    clear_model();
    chk("rst u0 comb", 32'({u0_stall, u0_branch, u0_jump}), 32'd0);
    chk("rst u1 comb", 32'({u1_stall, u1_branch, u1_jump}), 32'd0);
    check_regs(0);
    check_regs(1);
  endtask

  // Assert reset between edges and hold it with live stimulus applied.
  task automatic reset_hold(input int cycles);
    rst_n = 1'b0;
    valid = 1'b1; op = 6'b000100; rs = 5'd3; rt = 5'd3; exrt = 5'd3; flush = 1'b0;
    #1;
    check_all_zero();
    for (int c = 0; c < cycles; c++) begin
      op = (c % 2 == 0) ? 6'b100011 : 6'b000010;
      @(posedge clk);
      #1;
      check_all_zero();
    end
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] ops [7];
    logic [5:0] ro;
    int         sel;
    ops = '{6'b000000, 6'b001000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b111111};
    rst_n = 1'b0; valid = 1'b0; op = '0; rs = '0; rt = '0; exrt = '0; flush = 1'b0;
    clear_model();
    @(posedge clk);
    #1;
    reset_hold(2);

    // R, lw, sw back to back without dependencies, then drain.
    step(1'b1, 6'b000000, 5'd1, 5'd2, 5'd0, 1'b0);
    step(1'b1, 6'b100011, 5'd3, 5'd5, 5'd2, 1'b0);
    step(1'b1, 6'b101011, 5'd6, 5'd7, 5'd5, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 6'b000000, 5'd0, 5'd0, 5'd0, 1'b0);

    // Load-use: lw rt=5 then add rs=5; replay the add after the stall.
    step(1'b1, 6'b100011, 5'd2, 5'd5, 5'd0, 1'b0);
    step(1'b1, 6'b000000, 5'd5, 5'd9, 5'd5, 1'b0);
    step(1'b1, 6'b000000, 5'd5, 5'd9, 5'd0, 1'b0);

    // lw to $0 in EX, consumer reads $0: no stall.
    step(1'b1, 6'b100011, 5'd0, 5'd0, 5'd9, 1'b0);
    step(1'b1, 6'b000000, 5'd0, 5'd3, 5'd0, 1'b0);

    // beq followed by a flushed sw.
    step(1'b1, 6'b000100, 5'd1, 5'd2, 5'd0, 1'b0);
    step(1'b1, 6'b101011, 5'd3, 5'd4, 5'd2, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 6'b000000, 5'd0, 5'd0, 5'd0, 1'b0);

    // Stall and flush together on a beq.
    step(1'b1, 6'b100011, 5'd1, 5'd6, 5'd0, 1'b0);
    step(1'b1, 6'b000100, 5'd6, 5'd7, 5'd6, 1'b1);
    step(1'b1, 6'b000010, 5'd0, 5'd0, 5'd0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 6'b000000, 5'd0, 5'd0, 5'd0, 1'b0);

    // Illegal opcode four times (2-bit counter saturates), then with valid low.
    for (int i = 0; i < 4; i++) step(1'b1, 6'b111111, 5'd1, 5'd2, 5'd0, 1'b0);
    for (int i = 0; i < 2; i++) step(1'b0, 6'b111111, 5'd1, 5'd2, 5'd0, 1'b0);

    // Randomised traffic with small register ranges to provoke hazards.
    for (int i = 0; i < 400; i++) begin
      sel = int'($urandom_range(0, 7));
      ro  = (sel == 7) ? 6'($urandom) : ops[sel];
      step(($urandom_range(0, 99) < 85) ? 1'b1 : 1'b0, ro,
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           5'($urandom_range(0, 7)), ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0);
    end

    // Reset with a full pipeline in flight, then resume.
    step(1'b1, 6'b100011, 5'd1, 5'd4, 5'd0, 1'b0);
    step(1'b1, 6'b101011, 5'd2, 5'd3, 5'd4, 1'b0);
    step(1'b1, 6'b111111, 5'd2, 5'd3, 5'd0, 1'b0);
    reset_hold(2);
    step(1'b1, 6'b000000, 5'd1, 5'd2, 5'd0, 1'b0);
    step(1'b1, 6'b001000, 5'd3, 5'd4, 5'd2, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 6'b000000, 5'd0, 5'd0, 5'd0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
